// File: rtl/booth_pkg.sv
// booth_pkg: digit encoding and sizing helpers shared by the Booth multiplier.
package booth_pkg;

    typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_digit_e;

    function automatic int booth_groups(input int width);
        return (width + 2) / 2;
    endfunction

    function automatic booth_digit_e booth_encode(input logic [2:0] g);
        booth_digit_e d;
        unique case (g)
            3'b001, 3'b010: d = P1;
            3'b011:         d = P2;
            3'b100:         d = M2;
            3'b101, 3'b110: d = M1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_csa_reduce.sv
// booth_csa_reduce: 3:2 compressor tree folding N rows into a sum/carry pair.
module booth_csa_reduce #(
    parameter int N = 6,
    parameter int W = 24
) (
    input  logic [N-1:0][W-1:0] pp_i,
    output logic [W-1:0]        sum_o,
    output logic [W-1:0]        carry_o
);

    function automatic int rows_after(input int n, input int lv);
        int r;
        r = n;
        for (int k = 0; k < lv; k++) begin
            r = (r > 2) ? 2 * (r / 3) + r % 3 : r;
        end
        return r;
    endfunction

    function automatic int depth(input int n);
        int r;
        int d;
        r = n;
        d = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + r % 3;
            d++;
        end
        return d;
    endfunction

    localparam int L = depth(N);

    for (genvar l = 0; l <= L; l++) begin : g_lv
        localparam int NR = rows_after(N, l);
        logic [NR-1:0][W-1:0] row;
        if (l == 0) begin : g_in
            assign row = pp_i;
        end else begin : g_red
            localparam int NP = rows_after(N, l - 1);
            localparam int NT = NP / 3;
            for (genvar j = 0; j < NT; j++) begin : g_fa
                logic [W-1:0] x, y, z;
                assign x = g_lv[l-1].row[3*j];
                assign y = g_lv[l-1].row[3*j+1];
                assign z = g_lv[l-1].row[3*j+2];
                assign row[2*j]   = x ^ y ^ z;
                assign row[2*j+1] = ((x & y) | (x & z) | (y & z)) << 1;
            end
            // rows that do not fill a full compressor drop to the next level
            for (genvar k = 0; k < NP - 3 * NT; k++) begin : g_pass
                assign row[2*NT+k] = g_lv[l-1].row[3*NT+k];
            end
        end
    end

    assign sum_o   = g_lv[L].row[0];
    assign carry_o = g_lv[L].row[1];

endmodule

// File: rtl/booth_mul_pipe.sv
// booth_mul_pipe: 3-stage radix-4 Booth multiplier with valid/ready handshake.
// Define BOOTH_MUL_ACC_EN to add the running product accumulator (in_acc_clr/out_acc).
module booth_mul_pipe
    import booth_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int TAG_W = 4,
    parameter int ACC_W = 48
) (
    input  logic               clk,
    input  logic               rst,
`ifdef BOOTH_MUL_ACC_EN
    input  logic               in_acc_clr,
    output logic [ACC_W-1:0]   out_acc,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int G  = booth_groups(WIDTH);
    localparam int XW = WIDTH + 1;
    localparam int PW = 2 * WIDTH + 2;
    localparam int OW = 2 * WIDTH;

    logic                    adv;
    logic                    s1_vld_q, s2_vld_q, s3_vld_q;
    logic                    s1_mode_q, s2_mode_q, s3_mode_q;
    logic [TAG_W-1:0]        s1_tag_q, s2_tag_q, s3_tag_q;
    logic signed [XW-1:0]    s1_ax_d, s1_ax_q;
    booth_digit_e            s1_dig_d [G];
    booth_digit_e            s1_dig_q [G];
    logic signed [XW-1:0]    bs;
    logic [2*G:0]            bx;
    logic [PW-1:0]           a1, a2;
    logic [G-1:0][PW-1:0]    pp;
    logic [PW-1:0]           s2_sum_d, s2_carry_d;
    logic [PW-1:0]           s2_sum_q, s2_carry_q;
    logic [PW-1:0]           full;
    logic [OW-1:0]           s3_prod_d, s3_prod_q;
    logic                    unused_ok;

    assign adv       = !s3_vld_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = s3_vld_q;
    assign out_prod  = s3_prod_q;
    assign out_tag   = s3_tag_q;

    // multiplier gets sign/zero extension plus the implicit 0 below its LSB
    always_comb begin
        s1_ax_d = {in_signed & in_a[WIDTH-1], in_a};
        bs      = {in_signed & in_b[WIDTH-1], in_b};
        bx      = {(2 * G)'(bs), 1'b0};
        for (int i = 0; i < G; i++) begin
            s1_dig_d[i] = booth_encode(bx[2*i +: 3]);
        end
    end

    always_comb begin
        a1 = PW'(s1_ax_q);
        a2 = a1 << 1;
        for (int i = 0; i < G; i++) begin
            unique case (s1_dig_q[i])
                P1:      pp[i] = a1 << (2 * i);
                P2:      pp[i] = a2 << (2 * i);
                M1:      pp[i] = (-a1) << (2 * i);
                M2:      pp[i] = (-a2) << (2 * i);
                default: pp[i] = '0;
            endcase
        end
    end

    booth_csa_reduce #(
        .N (G),
        .W (PW)
    ) u_csa (
        .pp_i    (pp),
        .sum_o   (s2_sum_d),
        .carry_o (s2_carry_d)
    );

    assign full      = s2_sum_q + s2_carry_q;
    assign s3_prod_d = full[OW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s3_vld_q   <= 1'b0;
            s1_mode_q  <= 1'b0;
            s2_mode_q  <= 1'b0;
            s3_mode_q  <= 1'b0;
            s1_tag_q   <= '0;
            s2_tag_q   <= '0;
            s3_tag_q   <= '0;
            s1_ax_q    <= '0;
            for (int i = 0; i < G; i++) begin
                s1_dig_q[i] <= ZERO;
            end
            s2_sum_q   <= '0;
            s2_carry_q <= '0;
            s3_prod_q  <= '0;
        end else if (adv) begin
            s1_vld_q <= in_valid;
            s2_vld_q <= s1_vld_q;
            s3_vld_q <= s2_vld_q;
            if (in_valid) begin
                s1_mode_q <= in_signed;
                s1_tag_q  <= in_tag;
                s1_ax_q   <= s1_ax_d;
                s1_dig_q  <= s1_dig_d;
            end
            if (s1_vld_q) begin
                s2_mode_q  <= s1_mode_q;
                s2_tag_q   <= s1_tag_q;
                s2_sum_q   <= s2_sum_d;
                s2_carry_q <= s2_carry_d;
            end
            if (s2_vld_q) begin
                s3_mode_q <= s2_mode_q;
                s3_tag_q  <= s2_tag_q;
                s3_prod_q <= s3_prod_d;
            end
        end
    end

`ifdef BOOTH_MUL_ACC_EN
    logic             s1_clr_q, s2_clr_q, s3_clr_q;
    logic [ACC_W-1:0] acc_d, acc_q, pext;

    always_comb begin
        if (s3_mode_q) begin
            pext = ACC_W'(signed'(s3_prod_q));
        end else begin
            pext = ACC_W'(s3_prod_q);
        end
        acc_d = acc_q;
        if (s3_vld_q && out_ready) begin
            acc_d = (s3_clr_q ? '0 : acc_q) + pext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_clr_q <= 1'b0;
            s2_clr_q <= 1'b0;
            s3_clr_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            acc_q <= acc_d;
            if (adv) begin
                if (in_valid) s1_clr_q <= in_acc_clr;
                if (s1_vld_q) s2_clr_q <= s1_clr_q;
                if (s2_vld_q) s3_clr_q <= s2_clr_q;
            end
        end
    end

    assign out_acc   = acc_q;
    assign unused_ok = ^full[PW-1:OW];
`else
    localparam int unused_acc_w = ACC_W;
    assign unused_ok = ^{full[PW-1:OW], s3_mode_q};
`endif

endmodule

// File: tb/tb_booth_mul_pipe.sv
// tb_booth_mul_pipe: directed and randomized beats checked against plain
// integer multiplication, with ready stalls and a mid-stream reset.
`timescale 1ns/1ps
module tb_booth_mul_pipe;

    localparam int W = 11;
    localparam int T = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, in_signed;
    logic [W-1:0]   in_a, in_b;
    logic [T-1:0]   in_tag;
    logic           out_valid, out_ready;
    logic [2*W-1:0] out_prod;
    logic [T-1:0]   out_tag;

    booth_mul_pipe #(
        .WIDTH (W),
        .TAG_W (T),
        .ACC_W (48)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] prod;
        logic [T-1:0]   tag;
        int             cyc;
    } exp_t;

    exp_t           expq[$];
    int             total = 0;
    int             bad = 0;
    int             cyc = 0;
    int             sent = 0;
    logic           lat_chk;
    logic           bv, bsg;
    logic [W-1:0]   ba, bb;
    logic [T-1:0]   bt;
    logic [2*W-1:0] bexp;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic s,
            input logic [W-1:0] a, input logic [W-1:0] b);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return (2 * W)'(x * y);
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    task automatic newbeat(input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [T-1:0] t,
                           input logic [2*W-1:0] e);
        bv = 1'b1;
        bsg = s;
        ba = a;
        bb = b;
        bt = t;
        bexp = e;
    endtask

    task automatic rand_beat(input logic [T-1:0] t);
        logic s;
        logic [W-1:0] a, b;
        s = 1'($urandom_range(0, 1));
        a = pick();
        b = pick();
        newbeat(s, a, b, t, ref_mul(s, a, b));
    endtask

    task automatic cycle(input logic ordy);
        exp_t e;
        in_valid  = bv;
        in_signed = bsg;
        in_a      = ba;
        in_b      = bb;
        in_tag    = bt;
        out_ready = ordy;
        #1;
        if (out_valid) begin
            if (expq.size() == 0) begin
                chk("spurious", out_valid, 1'b0);
            end else begin
                chk("prod", out_prod, expq[0].prod);
                chk("tag", out_tag, expq[0].tag);
                if (ordy) begin
                    if (lat_chk) chk("latency", cyc - expq[0].cyc, 3);
                    expq.delete(0);
                end
            end
        end
        if (bv && in_ready) begin
            e.prod = bexp;
            e.tag = bt;
            e.cyc = cyc;
            expq.push_back(e);
            bv = 1'b0;
            sent++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((bv || expq.size() != 0) && n < budget) begin
            cycle(1'b1);
            tick();
            n++;
        end
        chk("drain", expq.size() + int'(bv), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        in_signed = 1'b0;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        out_ready = 1'b0;
        bv = 1'b0;
        bsg = 1'b0;
        ba = '0;
        bb = '0;
        bt = '0;
        bexp = '0;
        lat_chk = 1'b0;

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_prod", out_prod, 0);
        chk("rst_tag", out_tag, 0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1);
        chk("rst_ready", in_ready, 1'b1);
        tick();

        lat_chk = 1'b1;
        newbeat(1'b1, 11'h400, 11'h400, 4'h5, 22'h100000);
        drain(10);
        newbeat(1'b1, 11'h400, 11'h3FF, 4'hA, 22'h300400);
        drain(10);
        newbeat(1'b0, 11'h7FF, 11'h7FF, 4'h3, 22'h3FF001);
        drain(10);
        newbeat(1'b0, 11'h400, 11'h7FF, 4'hC, 22'h1FFC00);
        drain(10);

        lat_chk = 1'b0;
        sent = 0;
        for (int p = 0; p < 40 && (sent < 8 || bv || expq.size() != 0); p++) begin
            if (!bv && sent < 8) rand_beat(T'(sent));
            cycle(!(p >= 5 && p <= 9));
            if (p >= 5 && p <= 9) begin
                chk("stall_ready", in_ready, 1'b0);
                chk("stall_valid", out_valid, 1'b1);
            end
            tick();
        end
        chk("stall_sent", sent, 8);
        chk("stall_left", expq.size(), 0);

        lat_chk = 1'b1;
        for (int p = 0; p < 3; p++) begin
            rand_beat(T'(p + 1));
            cycle(1'b1);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_prod", out_prod, 0);
        chk("midrst_tag", out_tag, 0);
        expq.delete();
        bv = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        cycle(1'b1);
        chk("midrst_ready", in_ready, 1'b1);
        chk("midrst_stale", out_valid, 1'b0);
        tick();
        newbeat(1'b1, 11'h7FB, 11'd300, 4'h9, ref_mul(1'b1, 11'h7FB, 11'd300));
        drain(10);

        lat_chk = 1'b0;
        sent = 0;
        n = 0;
        while (sent < 10000 && n < 60000) begin
            if (!bv && $urandom_range(0, 3) != 0) rand_beat(T'($urandom));
            cycle($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        chk("rand_sent", sent, 10000);
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_mul_pipe.md
Name: booth_mul_pipe

Overview:
- Pipelined, parametrised radix-4 Booth multiplier. Successor to the combinational carry-save Booth array.
- Adds per-beat signed/unsigned mode, a 3-stage register pipeline with valid/ready backpressure, a resolved final product, and tag passthrough.
- Feeds the Kulisch accumulator and SIMD tensor-core datapath, where each lane instantiates one.

Parameters:
- WIDTH, 11: operand width in bits (≥4).
- TAG_W, 4: sideband tag width carried alongside each beat (≥1).
- ACC_W, 48: accumulator width; used only when BOOTH_MUL_ACC_EN is defined (≥2*WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_signed  in  1  1 = two's-complement operands; 0 = unsigned.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier (Booth-recoded).
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_prod  out  2*WIDTH  product: signed or unsigned per the beat's mode.
- out_tag  out  TAG_W  tag of the beat in out_prod.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values:
  - All stage valid bits = 0, so out_valid = 0.
  - out_prod = 0, out_tag = 0.
  - in_ready = 1 one cycle after rst deasserts (it is combinational: in_ready = !out_valid || out_ready).
  - Reset mid-operation discards all in-flight beats; no partial result is ever emitted.
- Operand extension: each operand is extended to WIDTH+1 bits by sign bit when in_signed=1, by zero otherwise. Booth group count G = (WIDTH+2)/2 over the extended multiplier with an implicit 0 below the LSB.
- Booth digit per group of bits {b(2i+1), b(2i), b(2i-1)}:
  - 000, 111 → 0
  - 001, 010 → +1
  - 011 → +2
  - 100 → −2
  - 101, 110 → −1
- Arithmetic: internal datapath width 2*WIDTH+2. Partial product i = digit*A shifted left by 2i. out_prod = low 2*WIDTH bits of the sum, which is exact for both modes (no overflow possible).
- Stage S1: register extended A, the Booth digits, mode and tag.
- Stage S2: generate partial products and reduce with 3:2 CSA rows to a sum/carry pair; register both.
- Stage S3: final carry-propagate add; register out_prod and out_tag.
- Latency: 3 cycles from in_valid&&in_ready to out_valid when unstalled. Throughput: 1 beat/cycle.
- Advance rule: advance = !out_valid || out_ready. All three stages move together when advance=1 and hold when advance=0 (global stall). Bubbles travel with valid=0.
- Handshake:
  - A beat is accepted only on in_valid && in_ready.
  - out_prod and out_tag are stable while out_valid && !out_ready.
  - The producer may drop in_valid at any time without penalty.
- Simultaneous events: a beat can be accepted in the same cycle the output is consumed. Beat ordering is strictly FIFO, with no reordering.

Optional Feature:
- Macro: BOOTH_MUL_ACC_EN.
- Defined:
  - Adds input in_acc_clr (1), output out_acc (ACC_W) and register acc (reset 0).
  - When a result beat is consumed (out_valid && out_ready), acc ← (beat's clr flag ? 0 : acc) + extended product. The product is sign-extended to ACC_W if the beat was signed, zero-extended otherwise.
  - in_acc_clr is captured with the beat and piped alongside it.
  - out_acc is registered and reflects acc; it wraps modulo 2^ACC_W.
- Undefined: no accumulator logic, no extra ports.

Decomposition:
- Package booth_pkg:
  - Enum typedef booth_digit_e {ZERO, P1, P2, M1, M2}.
  - booth_encode function (3 bits → digit).
  - localparam helper for G.
- Sub-module booth_csa_reduce:
  - Parametrised by count and width.
  - Combinational tree of 3:2 compressors taking N partial products down to a sum/carry pair.
  - Used in S2.

Test Plan:
- WIDTH=11, signed, a=−1024, b=−1024 → out_prod=0x100000 exactly 3 cycles after accept, out_tag matches input.
- Signed, a=−1024, b=1023 → 0x300400. Unsigned, a=2047, b=2047 → 0x3FF001. Unsigned, a=0x400, b=0x7FF → 0x1FFC00.
- Back-to-back stream of 8 beats with out_ready held 0 for cycles 5–9:
  - in_ready=0 while out_valid && !out_ready.
  - Held output stable.
  - All 8 results in order, none lost or duplicated.
- Assert rst mid-stream with 3 beats in flight → out_valid=0 immediately; after release, the first new beat produces a correct result with no stale output.
- Random 10k beats, mixed modes and random ready, against a reference model → all products and tags match.
- With BOOTH_MUL_ACC_EN:
  - Beats (3×4, clr=1), (−2×5 signed, clr=0) → out_acc = 12, then 2.
  - Unsigned 2047×2047 accumulated 4× → 0x0FFC004.
